// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: default bit timing, FSM state encoding
// and ASCII line terminators used by the matcher and its benches.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 10416;
  localparam int unsigned HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/uart_recv_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line does not fake an edge.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge aligned baud counter,
// one-cycle valid/frame_err strobes, BREAK state to ride out a held-low line.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] recv_data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_s;
  logic             rx_prev;

  rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_prev   <= 1'b1;
      recv_data <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_prev   <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              recv_data <= shift;
              valid     <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          baud_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv at 16 clocks/bit: frame-level reference model
// (expected good bytes, frame-error count, last good byte) vs observed strobes.
module tb_uart_recv;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] recv_data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         ferr_cnt = 0;
  int         proto_bad = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_recv #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .recv_data (recv_data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      obs_q.push_back(recv_data);
      obs_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if ((valid && frame_err) || (valid && prev_v) || (frame_err && prev_f)) proto_bad++;
    prev_v = valid;
    prev_f = frame_err;
  end

  // Drives one 10-bit frame starting at the current negedge; returns start cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
    t0 = cyc;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    uart_rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rst = 1'b1;
      checks++;
      if (recv_data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: data=%h valid=%b ferr=%b busy=%b, required 00 0 0 0",
                 i, recv_data, valid, frame_err, busy);
      end
      @(negedge clk);
    end
    last_good = 8'h00;
  endtask

  task automatic test_single_byte();
    int base = obs_q.size();
    int fb = ferr_cnt;
    int t0;
    int lat;
    send_frame(8'h73, 1'b1, t0);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d pulses, required 1", obs_q.size() - base);
    end else begin
      lat = obs_cyc[base] - t0;
      checks++;
      if (obs_q[base] !== 8'h73) begin
        errors++;
        $display("FAIL single_data: got %h, required 73", obs_q[base]);
      end
      checks++;
      if (lat < 153 || lat > 158) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles, required 153..158", lat);
      end
    end
    checks++;
    if (ferr_cnt !== fb) begin
      errors++;
      $display("FAIL single_ferr: got %0d pulses, required 0", ferr_cnt - fb);
    end
    last_good = 8'h73;
    checks++;
    if (recv_data !== last_good) begin
      errors++;
      $display("FAIL single_hold: got %h, required %h", recv_data, last_good);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    int base = obs_q.size();
    int t0;
    exp[0] = 8'h68; exp[1] = 8'h69; exp[2] = CR;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, t0);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, required 3", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[base+i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h, required %h", i, obs_q[base+i], exp[i]);
        end
        if (i > 0) begin
          checks++;
          if (obs_cyc[base+i] - obs_cyc[base+i-1] !== 10*CPB) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d, required %0d", i,
                     obs_cyc[base+i] - obs_cyc[base+i-1], 10*CPB);
          end
        end
      end
    end
    last_good = CR;
  endtask

  task automatic test_glitch();
    int base = obs_q.size();
    int fb = ferr_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() !== base || ferr_cnt !== fb) begin
      errors++;
      $display("FAIL glitch_pulses: valid=%0d ferr=%0d, required 0 0", obs_q.size() - base, ferr_cnt - fb);
    end
    checks++;
    if (recv_data !== last_good || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_state: data=%h busy=%b, required %h 0", recv_data, busy, last_good);
    end
  endtask

  task automatic test_framing_error();
    int base = obs_q.size();
    int fb = ferr_cnt;
    int t0;
    logic busy_low = 1'b1;
    t0 = cyc;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = 8'h41 >> i;
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 20 && busy !== 1'b1) busy_low = 1'b0;
    end
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ferr_cnt - fb !== 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - fb);
    end
    checks++;
    if (obs_q.size() !== base) begin
      errors++;
      $display("FAIL ferr_valid: got %0d valid pulses, required 0", obs_q.size() - base);
    end
    checks++;
    if (busy_low !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_held: busy dropped while line low, required 1");
    end
    checks++;
    if (busy !== 1'b0 || recv_data !== last_good) begin
      errors++;
      $display("FAIL ferr_recover: busy=%b data=%h, required 0 %h", busy, recv_data, last_good);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = obs_q.size();
    int fb = ferr_cnt;
    int t0;
    logic [7:0] b = 8'h74;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || recv_data !== last_good) begin
      errors++;
      $display("FAIL midrst_state: busy=%b data=%h, required 0 00", busy, recv_data);
    end
    repeat (40) @(negedge clk);
    send_frame(8'h70, 1'b1, t0);
    repeat (30) @(negedge clk);
    last_good = 8'h70;
    checks++;
    if (obs_q.size() - base !== 1 || ferr_cnt !== fb) begin
      errors++;
      $display("FAIL midrst_count: valid=%0d ferr=%0d, required 1 0", obs_q.size() - base, ferr_cnt - fb);
    end else begin
      checks++;
      if (obs_q[base] !== 8'h70) begin
        errors++;
        $display("FAIL midrst_data: got %h, required 70", obs_q[base]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int base = obs_q.size();
    int fb = ferr_cnt;
    int exp_ferr = 0;
    int t0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b = 8'($urandom);
      logic good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, t0);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end else begin
        exp_ferr++;
        repeat (20 + $urandom_range(0, 10)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() - base !== exp_q.size() || ferr_cnt - fb !== exp_ferr) begin
      errors++;
      $display("FAIL rand_count: valid=%0d ferr=%0d, required %0d %0d",
               obs_q.size() - base, ferr_cnt - fb, exp_q.size(), exp_ferr);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data%0d: got %h, required %h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (recv_data !== last_good) begin
      errors++;
      $display("FAIL rand_hold: got %h, required %h", recv_data, last_good);
    end
  endtask

  task automatic test_strobes();
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL strobe_rules: got %0d overlapping/stretched strobes, required 0", proto_bad);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random();
    test_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
